// File: rtl/pwm_pkg.sv
// Shared types for the pwm datapath.
// Ramp FSM states and the common duty-level width.
package pwm_pkg;

  localparam int PWM_LEVEL_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/pwm_ramp_tick.sv
// Ramp step timebase: one-cycle tick every TICK_CYCLES enabled clocks.
// TICK_CYCLES=1 gives a tick on every enabled cycle.
module pwm_ramp_tick #(
  parameter int TICK_CYCLES = 100000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  input  logic enable_in,
  output logic tick_out
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap at LAST, hold when disabled, zero on clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_in) begin
      cnt_d = '0;
    end else if (enable_in) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_out = enable_in && !clear_in && (cnt_q == LAST);

endmodule

// File: rtl/pwm_level_ramp.sv
// Duty-level slew limiter feeding pwm level_in.
// Fades toward a handshaken target, or breathes between two limits.
module pwm_level_ramp
  import pwm_pkg::*;
#(
  parameter int LEVEL_WIDTH = PWM_LEVEL_WIDTH,
  parameter int TICK_CYCLES = 100000,
  parameter int STEP_SIZE   = 1,
  parameter int BREATHE_MIN = 0,
  parameter int BREATHE_MAX = 255
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [LEVEL_WIDTH-1:0] target_in,
  input  logic                   target_valid_in,
  output logic                   target_ready_out,
  input  logic                   breathe_in,
  output logic [LEVEL_WIDTH-1:0] level_out,
  output logic                   busy_out,
  output logic                   done_out
);

  localparam int W1 = LEVEL_WIDTH + 1;
  localparam logic [LEVEL_WIDTH-1:0] STEP_L = LEVEL_WIDTH'(STEP_SIZE);
  localparam logic [W1-1:0] STEP_W = W1'(STEP_SIZE);
  localparam logic [LEVEL_WIDTH-1:0] BMIN = LEVEL_WIDTH'(BREATHE_MIN);
  localparam logic [LEVEL_WIDTH-1:0] BMAX = LEVEL_WIDTH'(BREATHE_MAX);

  ramp_state_t state_q, state_d;
  logic [LEVEL_WIDTH-1:0] lvl_q, lvl_d;
  logic [LEVEL_WIDTH-1:0] tgt_q, tgt_d;
  logic brth_q, brth_d;
  logic done_q, done_d;
  logic busy_q;

  logic accept;
  logic clr;
  logic tick;
  logic [W1-1:0] diff_up;
  logic [W1-1:0] diff_dn;
  logic [LEVEL_WIDTH-1:0] up_nxt;
  logic [LEVEL_WIDTH-1:0] dn_nxt;

  assign target_ready_out = (state_q == IDLE) && !rst_in;
  assign accept = target_valid_in && target_ready_out;

  pwm_ramp_tick #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear_in (clr),
    .enable_in(state_q != IDLE),
    .tick_out (tick)
  );

  // Saturating single-step candidates; wide diffs avoid wrap.
  always_comb begin
    diff_up = {1'b0, tgt_q} - {1'b0, lvl_q};
    diff_dn = {1'b0, lvl_q} - {1'b0, tgt_q};
    up_nxt  = (diff_up <= STEP_W) ? tgt_q : lvl_q + STEP_L;
    dn_nxt  = (diff_dn <= STEP_W) ? tgt_q : lvl_q - STEP_L;
  end

  // Ramp FSM next-state: start, step, turnaround, finish.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    tgt_d   = tgt_q;
    brth_d  = brth_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d = target_in;
          clr   = 1'b1;
          if (target_in > lvl_q) begin
            state_d = UP;
          end else if (target_in < lvl_q) begin
            state_d = DOWN;
          end else begin
            done_d = 1'b1;
          end
        end else if (breathe_in) begin
          brth_d  = 1'b1;
          tgt_d   = BMAX;
          clr     = 1'b1;
          state_d = (lvl_q > BMAX) ? DOWN : UP;
        end
      end
      UP: begin
        if (tick) begin
          lvl_d = up_nxt;
          if (up_nxt == tgt_q) begin
            if (brth_q && breathe_in) begin
              tgt_d   = BMIN;
              state_d = DOWN;
            end else begin
              brth_d  = 1'b0;
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      DOWN: begin
        if (tick) begin
          lvl_d = dn_nxt;
          if (dn_nxt == tgt_q) begin
            if (brth_q && breathe_in) begin
              tgt_d   = BMAX;
              state_d = UP;
            end else begin
              brth_d  = 1'b0;
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      lvl_q   <= '0;
      tgt_q   <= '0;
      brth_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      tgt_q   <= tgt_d;
      brth_q  <= brth_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign level_out = lvl_q;
  assign busy_out  = busy_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_pwm_level_ramp.sv
// Directed bench for pwm_level_ramp.
// Three instances cover STEP_SIZE 1 (with breathe), 4 and 7.
module tb_pwm_level_ramp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [3];
  logic [7:0] tgt  [3];
  logic       vld  [3];
  logic       brt  [3];
  logic       rdy  [3];
  logic [7:0] lvl  [3];
  logic       busy [3];
  logic       done [3];

  int checks = 0;
  int errors = 0;

  pwm_level_ramp #(
    .LEVEL_WIDTH(8), .TICK_CYCLES(4), .STEP_SIZE(1),
    .BREATHE_MIN(2), .BREATHE_MAX(5)
  ) u_a (
    .clk_in(clk), .rst_in(rst[0]),
    .target_in(tgt[0]), .target_valid_in(vld[0]),
    .target_ready_out(rdy[0]), .breathe_in(brt[0]),
    .level_out(lvl[0]), .busy_out(busy[0]), .done_out(done[0])
  );

  pwm_level_ramp #(
    .LEVEL_WIDTH(8), .TICK_CYCLES(4), .STEP_SIZE(4),
    .BREATHE_MIN(0), .BREATHE_MAX(255)
  ) u_b (
    .clk_in(clk), .rst_in(rst[1]),
    .target_in(tgt[1]), .target_valid_in(vld[1]),
    .target_ready_out(rdy[1]), .breathe_in(brt[1]),
    .level_out(lvl[1]), .busy_out(busy[1]), .done_out(done[1])
  );

  pwm_level_ramp #(
    .LEVEL_WIDTH(8), .TICK_CYCLES(4), .STEP_SIZE(7),
    .BREATHE_MIN(0), .BREATHE_MAX(255)
  ) u_c (
    .clk_in(clk), .rst_in(rst[2]),
    .target_in(tgt[2]), .target_valid_in(vld[2]),
    .target_ready_out(rdy[2]), .breathe_in(brt[2]),
    .level_out(lvl[2]), .busy_out(busy[2]), .done_out(done[2])
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic chk_st(input int k, input string tag, input int l,
                        input int b, input int d);
    chk({tag, "_lvl"}, 32'(lvl[k]), l);
    chk({tag, "_busy"}, 32'(busy[k]), b);
    chk({tag, "_done"}, 32'(done[k]), d);
  endtask

  int seq [10] = '{1, 2, 3, 4, 5, 4, 3, 2, 3, 4};

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      tgt[k] = '0;
      vld[k] = 1'b0;
      brt[k] = 1'b0;
    end
    tick(2);
    for (int k = 0; k < 3; k++) begin
      chk_st(k, "rst", 0, 0, 0);
      chk("rst_rdy", 32'(rdy[k]), 0);
      rst[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 3; k++) chk("rel_rdy", 32'(rdy[k]), 1);

    // Scenario 1: 0 -> 10, step 1
    tgt[0] = 8'd10; vld[0] = 1'b1;
    tick(1);
    vld[0] = 1'b0;
    chk_st(0, "s1_acc", 0, 1, 0);
    chk("s1_rdy_lo", 32'(rdy[0]), 0);
    tick(3);
    chk_st(0, "s1_n3", 0, 1, 0);
    tick(1);
    chk_st(0, "s1_n4", 1, 1, 0);
    tick(35);
    chk_st(0, "s1_n39", 9, 1, 0);
    tick(1);
    chk_st(0, "s1_end", 10, 0, 1);
    chk("s1_rdy_hi", 32'(rdy[0]), 1);
    tick(1);
    chk_st(0, "s1_post", 10, 0, 0);

    // Scenario 3a: target equals level
    vld[0] = 1'b1;
    tick(1);
    vld[0] = 1'b0;
    chk_st(0, "s3_eq", 10, 0, 1);
    tick(1);
    chk_st(0, "s3_eq_post", 10, 0, 0);

    // Scenario 4: breathe 2..5 from 0
    rst[0] = 1'b1;
    tick(1);
    rst[0] = 1'b0;
    brt[0] = 1'b1;
    tick(1);
    chk_st(0, "s4_start", 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 4; j++) begin
        tick(1);
        chk("s4_nodone", 32'(done[0]), 0);
      end
      chk("s4_lvl", 32'(lvl[0]), seq[i]);
      chk("s4_busy", 32'(busy[0]), 1);
    end
    brt[0] = 1'b0;
    tick(4);
    chk_st(0, "s4_stop", 5, 0, 1);
    tick(1);
    chk_st(0, "s4_post", 5, 0, 0);

    // Scenario 5: valid beats breathe; valid held while busy
    rst[0] = 1'b1;
    tick(1);
    rst[0] = 1'b0;
    tgt[0] = 8'd7; vld[0] = 1'b1; brt[0] = 1'b1;
    tick(1);
    vld[0] = 1'b0;
    chk_st(0, "s5_acc", 0, 1, 0);
    tick(27);
    chk_st(0, "s5_n27", 6, 1, 0);
    tick(1);
    chk_st(0, "s5_end", 7, 0, 1);
    brt[0] = 1'b0;
    tick(1);
    chk_st(0, "s5_post", 7, 0, 0);
    tgt[0] = 8'd9; vld[0] = 1'b1;
    tick(1);
    chk_st(0, "s5_acc2", 7, 1, 0);
    tgt[0] = 8'd0;
    tick(2);
    chk("s5_busy_rdy", 32'(rdy[0]), 0);
    chk_st(0, "s5_held", 7, 1, 0);
    tick(6);
    chk_st(0, "s5_end2", 9, 0, 1);
    chk("s5_rdy2", 32'(rdy[0]), 1);
    tick(1);
    vld[0] = 1'b0;
    chk_st(0, "s5_acc3", 9, 1, 0);
    tick(12);
    chk_st(0, "s5_at6", 6, 1, 0);

    // Scenario 6: reset mid-ramp at level 6
    rst[0] = 1'b1;
    #1;
    chk("s6_rdy_rst", 32'(rdy[0]), 0);
    tick(1);
    chk_st(0, "s6_rst", 0, 0, 0);
    chk("s6_rdy_rst2", 32'(rdy[0]), 0);
    rst[0] = 1'b0;
    #1;
    chk("s6_rdy_rel", 32'(rdy[0]), 1);
    tick(5);
    chk_st(0, "s6_quiet", 0, 0, 0);

    // Scenario 2: step 4, 0->10 then 10->3
    tgt[1] = 8'd10; vld[1] = 1'b1;
    tick(1);
    vld[1] = 1'b0;
    tick(4);
    chk_st(1, "s2_u1", 4, 1, 0);
    tick(4);
    chk_st(1, "s2_u2", 8, 1, 0);
    tick(4);
    chk_st(1, "s2_u3", 10, 0, 1);
    tick(1);
    tgt[1] = 8'd3; vld[1] = 1'b1;
    tick(1);
    vld[1] = 1'b0;
    chk_st(1, "s2_dacc", 10, 1, 0);
    tick(4);
    chk_st(1, "s2_d1", 6, 1, 0);
    tick(4);
    chk_st(1, "s2_d2", 3, 0, 1);
    tick(1);
    chk_st(1, "s2_post", 3, 0, 0);

    // Scenario 3b: step 7 up to 255, no wrap
    tgt[2] = 8'd255; vld[2] = 1'b1;
    tick(1);
    vld[2] = 1'b0;
    tick(144);
    chk_st(2, "s3_252", 252, 1, 0);
    tick(4);
    chk_st(2, "s3_255", 255, 0, 1);
    tick(4);
    chk_st(2, "s3_post", 255, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_level_ramp.md
Name: pwm_level_ramp

Overview:
Upstream feeder for the pwm stage: produces the 8-bit duty level consumed on pwm level_in.
- Accepts a target level over a valid/ready handshake.
- Slews level_out toward the target by STEP_SIZE once every TICK_CYCLES clocks, so LED/motor brightness fades rather than jumps.
- Optional breathe mode ramps continuously between BREATHE_MIN and BREATHE_MAX with no host traffic.

Parameters:
LEVEL_WIDTH, 8, width of target_in and level_out; matches pwm level_in.
TICK_CYCLES, 100000, clocks per ramp step (1 ms at 100 MHz); must be >= 1.
STEP_SIZE, 1, level increment/decrement per tick; must be >= 1.
BREATHE_MIN, 0, lower turnaround level in breathe mode.
BREATHE_MAX, 255, upper turnaround level in breathe mode; must be > BREATHE_MIN.

Ports:
clk_in  input  1  system clock, 100 MHz.
rst_in  input  1  synchronous, active-high reset.
target_in  input  LEVEL_WIDTH  requested final level.
target_valid_in  input  1  target_in is valid this cycle.
target_ready_out  output  1  block can accept a target this cycle.
breathe_in  input  1  level-sensitive request for continuous breathe mode.
level_out  output  LEVEL_WIDTH  current duty level; drives pwm level_in.
busy_out  output  1  high whenever state is not IDLE.
done_out  output  1  one-cycle pulse when a ramp ends and the block returns to IDLE.

Behaviour:
- Interface: one clock (clk_in); reset rst_in is synchronous and active-high.
- Reset: on any edge with rst_in high:
  - state=IDLE, level_out=0, tick counter=0, target register=0, breathing flag=0, done_out=0.
  - target_ready_out is forced 0 while rst_in is high.
  - Mid-ramp reset abandons the ramp with no done_out pulse.
- States: IDLE, UP, DOWN.
- target_ready_out = (state==IDLE) && !rst_in, combinational.
- IDLE, valid&&ready on edge N:
  - Target is latched; tick counter is cleared.
  - target > level_out: UP at N+1. target < level_out: DOWN at N+1.
  - target == level_out: stay IDLE; done_out high during cycle N+1.
- IDLE, breathe_in high and no valid:
  - Set breathing flag, latch target=BREATHE_MAX, enter UP, or DOWN if level_out > BREATHE_MAX.
  - A valid target has priority over breathe_in in the same cycle.
- Tick counter: counts 0..TICK_CYCLES-1 while in UP/DOWN, wraps to 0. A step occurs on the edge where counter==TICK_CYCLES-1.
  - First step lands TICK_CYCLES clocks after entering UP/DOWN.
- UP step: if target-level_out <= STEP_SIZE, level_out=target; else level_out += STEP_SIZE. Never overshoots and never wraps past 2^LEVEL_WIDTH-1.
- DOWN step: symmetric, saturating at target; never underflows below 0.
- Differences are computed in LEVEL_WIDTH+1 bits.
- On the step that makes level_out==target:
  - Breathing flag set and breathe_in still high: swap direction. Target becomes BREATHE_MIN (from UP) or BREATHE_MAX (from DOWN); the counter continues; no done_out.
  - Otherwise: clear breathing flag, go to IDLE, done_out high the following cycle.
- breathe_in falling mid-ramp: the current ramp completes, then the block goes to IDLE with a done_out pulse.
- target_valid_in while busy: ignored (ready low); the source must hold valid until ready.
- level_out is registered; no combinational path from inputs.
- busy_out is registered, equal to (state != IDLE).

Decomposition:
- Package pwm_pkg holds:
  - typedef enum logic [1:0] {IDLE, UP, DOWN} ramp_state_t;
  - localparam PWM_LEVEL_WIDTH = 8, shared with the pwm module.
- Sub-module pwm_ramp_tick: parameterised TICK_CYCLES counter with clear_in/enable_in and a one-cycle tick_out. $clog2 width; TICK_CYCLES=1 yields tick every enabled cycle.

Test Plan:
All scenarios use TICK_CYCLES=4, STEP_SIZE=1 unless noted.
1. Reset, then target 10 accepted at edge N: level_out stays 0 through N+3, reaches 1 at N+4, reaches 10 at N+40; busy high throughout; done_out pulses at N+41; ready returns high.
2. From level 10, target 3 with STEP_SIZE=4: level_out goes 10->6->3 (saturates, no underflow); done_out one pulse.
3. Target equal to level_out (10 at 10): no busy, done_out pulses the next cycle; target 255 with STEP_SIZE=7 ends exactly at 255 with no wrap.
4. Breathe with BREATHE_MIN=2, BREATHE_MAX=5, breathe_in held high: level_out sequences 0,1,2,3,4,5,4,3,2,3,... with no done_out. Drop breathe_in mid-rise at 4: stops at 5, done_out pulses once.
5. Valid and breathe_in asserted together in IDLE with target 7: target ramp taken, breathing flag stays 0. valid asserted while busy: not accepted; accepted on the first ready cycle.
6. rst_in pulsed mid-ramp at level 6: next edge level_out=0, state IDLE, no done_out; ready low during the reset cycle and high after.
